wb_stage: RTL and testbench

MEM/WB pipeline register and writeback unit of the 5-stage RV32I core. Captures the MEM-stage result bundle, formats load data (byte/halfword select, sign/zero extension) and selects the writeback value. Drives the register file write port one cycle after MEM. Also supplies the ID stage with write-through bypassed operands, since the register file has no internal same-cycle bypass.

---
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback unit for the RV32I core.
// Captures the MEM result bundle, formats load data, selects the writeback
// value, drives the register-file write port and supplies write-through
// bypassed operands to ID.
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction
// counter on the `instret` port.

package riscv_pkg;
  parameter int XLEN = 32;
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [4:0]      reg_addr_t;
endpackage

module wb_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic                  mem_rd_we,
  input  riscv_pkg::reg_addr_t  mem_rd_addr,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_byte_off,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  input  logic [XLEN-1:0]       mem_load_word,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rf_we,
  output riscv_pkg::reg_addr_t  rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_data,
  output logic                  wb_valid,
  input  riscv_pkg::reg_addr_t  id_rs1_addr,
  input  riscv_pkg::reg_addr_t  id_rs2_addr,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  output logic [XLEN-1:0]       id_rs1_data,
  output logic [XLEN-1:0]       id_rs2_data
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  typedef struct packed {
    logic                 valid;
    logic                 rd_we;
    riscv_pkg::reg_addr_t rd_addr;
    logic [1:0]           wb_sel;
    logic [2:0]           funct3;
    logic [1:0]           byte_off;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      load_word;
  } wb_reg_t;

  wb_reg_t         wb_q, wb_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_fmt;

  // Next WB register: flush kills the slot (fields left as they were),
  // stall holds everything, otherwise take the MEM bundle.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d.valid = 1'b0;
    end else if (!stall) begin
      wb_d.valid      = mem_valid;
      wb_d.rd_we      = mem_rd_we;
      wb_d.rd_addr    = mem_rd_addr;
      wb_d.wb_sel     = mem_wb_sel;
      wb_d.funct3     = mem_funct3;
      wb_d.byte_off   = mem_byte_off;
      wb_d.alu_result = mem_alu_result;
      wb_d.pc_plus4   = mem_pc_plus4;
      wb_d.load_word  = mem_load_word;
    end
  end

  // WB register, cleared asynchronously so every rf_* output reads zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_q <= '0;
    else        wb_q <= wb_d;
  end

  // Load formatting: byte lane from the full offset, halfword lane from
  // offset bit 1 only (misaligned halves are not split across words).
  always_comb begin
    byte_sel = wb_q.load_word[{wb_q.byte_off, 3'b000} +: 8];
    half_sel = wb_q.load_word[{wb_q.byte_off[1], 4'b0000} +: 16];
    case (wb_q.funct3)
      3'b000:  load_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, half_sel};
      default: load_fmt = wb_q.load_word;
    endcase
  end

  // Writeback select and register-file write port; x0 writes are suppressed here.
  always_comb begin
    case (wb_q.wb_sel)
      2'b01:   rf_rd_data = load_fmt;
      2'b10:   rf_rd_data = wb_q.pc_plus4;
      default: rf_rd_data = wb_q.alu_result;
    endcase
    wb_valid   = wb_q.valid;
    rf_rd_addr = wb_q.rd_addr;
    rf_we      = wb_q.valid & wb_q.rd_we & (wb_q.rd_addr != '0);
  end

  // Write-through bypass: the register file reads old data in the write cycle.
  // rf_we already excludes x0, so x0 never bypasses.
  always_comb begin
    id_rs1_data = (rf_we && id_rs1_addr == wb_q.rd_addr) ? rf_rd_data : rf_rs1_data;
    id_rs2_data = (rf_we && id_rs2_addr == wb_q.rd_addr) ? rf_rd_data : rf_rs2_data;
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // A slot retires on the edge it leaves WB unstalled; natural 64-bit wrap.
  always_comb begin
    instret_d = instret_q;
    if (wb_q.valid && !stall) instret_d = instret_q + 64'd1;
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. The driver pushes the expected
// WB-cycle response for each MEM slot it issues; a monitor on the falling edge
// pops entries when their cycle arrives and compares all writeback outputs.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 0, mem_rd_we = 0;
  logic [4:0]  mem_rd_addr = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [1:0]  mem_byte_off = '0;
  logic [31:0] mem_alu_result = '0, mem_pc_plus4 = '0, mem_load_word = '0;
  logic        stall = 0, flush = 0;
  logic        rf_we, wb_valid;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0;
  logic [31:0] rf_rs1_data = 32'hA1A1_0001, rf_rs2_data = 32'hB2B2_0002;
  logic [31:0] id_rs1_data, id_rs2_data;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_byte_off(mem_byte_off),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_load_word(mem_load_word), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .wb_valid(wb_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic        v, we, chkd;
    logic [4:0]  addr;
    logic [31:0] data, rs1, rs2;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;
  localparam logic [31:0] LW = 32'h80FF_7F01;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every entry that is due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due != cyc) chk({e.name, ".late"}, 64'(e.due), 64'(cyc));
      chk({e.name, ".wb_valid"}, 64'(wb_valid), 64'(e.v));
      chk({e.name, ".rf_we"},    64'(rf_we),    64'(e.we));
      if (e.v)    chk({e.name, ".rd_addr"}, 64'(rf_rd_addr), 64'(e.addr));
      if (e.chkd) chk({e.name, ".rd_data"}, 64'(rf_rd_data), 64'(e.data));
      chk({e.name, ".id_rs1"}, 64'(id_rs1_data), 64'(e.rs1));
      chk({e.name, ".id_rs2"}, 64'(id_rs2_data), 64'(e.rs2));
    end
  end

  // Drive one MEM slot after the edge and push the response expected in WB next cycle.
  task automatic issue(input string nm, input logic v, we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] alu, pc, lw, input logic st, fl,
                       input logic ev, ewe, input logic [4:0] ea, input logic [31:0] ed,
                       input logic chkd, input logic [31:0] ers1, ers2);
    exp_t e;
    @(posedge clk); #1;
    mem_valid = v; mem_rd_we = we; mem_rd_addr = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_byte_off = off; mem_alu_result = alu;
    mem_pc_plus4 = pc; mem_load_word = lw; stall = st; flush = fl;
    e.due = cyc + 1; e.name = nm; e.v = ev; e.we = ewe; e.addr = ea;
    e.data = ed; e.chkd = chkd; e.rs1 = ers1; e.rs2 = ers2;
    sb.push_back(e);
  endtask

  // Simple slot: valid, no stall/flush, expected data given, default bypass pass-through.
  task automatic slot(input string nm, input logic we, input logic [4:0] rd,
                      input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                      input logic [31:0] alu, input logic ewe, input logic [31:0] ed,
                      input logic [31:0] ers1, ers2);
    issue(nm, 1'b1, we, rd, sel, f3, off, alu, 32'h0000_0104, LW, 1'b0, 1'b0,
          1'b1, ewe, rd, ed, 1'b1, ers1, ers2);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin @(posedge clk); n++; end
    @(negedge clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2;
    r1 = rf_rs1_data; r2 = rf_rs2_data;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.wb_valid", 64'(wb_valid), 64'd0);
    chk("rst.rf_we",    64'(rf_we),    64'd0);
    chk("rst.rd_addr",  64'(rf_rd_addr), 64'd0);
    chk("rst.rd_data",  64'(rf_rd_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ALU writeback and x0 suppression
    slot("alu_rd5",  1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h1234_5678, 1, 32'h1234_5678, r1, r2);
    slot("alu_rd0",  1, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0BAD_0000, 0, 32'h0BAD_0000, r1, r2);
    slot("alu_sel3", 1, 5'd6, 2'b11, 3'b000, 2'd0, 32'h00C0_FFEE, 1, 32'h00C0_FFEE, r1, r2);
    slot("alu_we0",  0, 5'd6, 2'b00, 3'b000, 2'd0, 32'h0000_1111, 0, 32'h0000_1111, r1, r2);
    // Loads from 0x80FF_7F01
    slot("lb_off3",  1, 5'd1, 2'b01, 3'b000, 2'd3, 32'h0, 1, 32'hFFFF_FF80, r1, r2);
    slot("lbu_off1", 1, 5'd1, 2'b01, 3'b100, 2'd1, 32'h0, 1, 32'h0000_007F, r1, r2);
    slot("lh_off2",  1, 5'd1, 2'b01, 3'b001, 2'd2, 32'h0, 1, 32'hFFFF_80FF, r1, r2);
    slot("lhu_off3", 1, 5'd1, 2'b01, 3'b101, 2'd3, 32'h0, 1, 32'h0000_80FF, r1, r2);
    slot("lw_off2",  1, 5'd1, 2'b01, 3'b010, 2'd2, 32'h0, 1, 32'h80FF_7F01, r1, r2);
    slot("lb_off2",  1, 5'd1, 2'b01, 3'b000, 2'd2, 32'h0, 1, 32'hFFFF_FFFF, r1, r2);
    slot("lh_off0",  1, 5'd1, 2'b01, 3'b001, 2'd0, 32'h0, 1, 32'h0000_7F01, r1, r2);
    slot("lhu_off1", 1, 5'd1, 2'b01, 3'b101, 2'd1, 32'h0, 1, 32'h0000_7F01, r1, r2);
    slot("raw_011",  1, 5'd1, 2'b01, 3'b011, 2'd1, 32'h0, 1, 32'h80FF_7F01, r1, r2);
    slot("link",     1, 5'd2, 2'b10, 3'b000, 2'd0, 32'h0000_0999, 1, 32'h0000_0104, r1, r2);
    issue("invalid", 0, 1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h0000_2222, 32'h0, LW, 0, 0,
          0, 0, 5'd5, 32'h0000_2222, 1, r1, r2);
    // Stall / flush priority
    slot("st_a", 1, 5'd9, 2'b00, 3'b000, 2'd0, 32'hAAAA_0001, 1, 32'hAAAA_0001, r1, r2);
    issue("st_hold", 1, 1, 5'd10, 2'b00, 3'b000, 2'd0, 32'hBBBB_0002, 32'h0, LW, 1, 0,
          1, 1, 5'd9, 32'hAAAA_0001, 1, r1, r2);
    issue("st_flush", 1, 1, 5'd11, 2'b00, 3'b000, 2'd0, 32'hCCCC_0003, 32'h0, LW, 1, 1,
          0, 0, 5'd0, 32'h0, 0, r1, r2);
    slot("st_d", 1, 5'd12, 2'b00, 3'b000, 2'd0, 32'hDDDD_0004, 1, 32'hDDDD_0004, r1, r2);
    issue("flush_only", 1, 1, 5'd13, 2'b00, 3'b000, 2'd0, 32'hEEEE_0005, 32'h0, LW, 0, 1,
          0, 0, 5'd0, 32'h0, 0, r1, r2);
    slot("st_f", 1, 5'd14, 2'b00, 3'b000, 2'd0, 32'hFFFF_0006, 1, 32'hFFFF_0006, r1, r2);
    drain();

    // Bypass
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd8; rf_rs1_data = 32'h1; rf_rs2_data = 32'h22;
    slot("byp_x7", 1, 5'd7, 2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h22);
    slot("byp_x8", 1, 5'd8, 2'b00, 3'b000, 2'd0, 32'h1212_1212, 1, 32'h1212_1212, 32'h1, 32'h1212_1212);
    slot("byp_we0", 0, 5'd7, 2'b00, 3'b000, 2'd0, 32'h0000_0077, 0, 32'h0000_0077, 32'h1, 32'h22);
    issue("byp_inv", 0, 1, 5'd7, 2'b00, 3'b000, 2'd0, 32'h0000_0078, 32'h0, LW, 0, 0,
          0, 0, 5'd7, 32'h0000_0078, 1, 32'h1, 32'h22);
    drain();
    id_rs1_addr = 5'd0;
    slot("byp_x0", 1, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0000_0005, 0, 32'h0000_0005, 32'h1, 32'h22);
    r1 = 32'h1; r2 = 32'h22;
    drain();

    // Asynchronous reset with a valid slot in WB, then first slot after release
    slot("pre_rst", 1, 5'd3, 2'b00, 3'b000, 2'd0, 32'h0000_0033, 1, 32'h0000_0033, r1, r2);
    drain();
    #2 rst_n = 1'b0;
    #1;
    chk("amid_rst.wb_valid", 64'(wb_valid), 64'd0);
    chk("amid_rst.rf_we",    64'(rf_we),    64'd0);
    chk("amid_rst.rd_data",  64'(rf_rd_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    slot("post_rst", 1, 5'd4, 2'b00, 3'b000, 2'd0, 32'h0000_0044, 1, 32'h0000_0044, r1, r2);
    issue("idle", 0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, LW, 0, 0,
          0, 0, 5'd0, 32'h0, 0, r1, r2);
    drain();

`ifdef WB_INSTRET_EN
    begin
      logic [31:0] last_alu;
      last_alu = '0;
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 13; i++) begin
        if (i == 3 || i == 7 || i == 10)
          issue("ir_stall", 1, 1, 5'd1, 2'b00, 3'b000, 2'd0, 32'h0000_0F00, 32'h0, LW, 1, 0,
                1, 1, 5'd1, last_alu, 1, r1, r2);
        else begin
          last_alu = 32'h100 + 32'(i);
          slot("ir_slot", 1, 5'd1, 2'b00, 3'b000, 2'd0, last_alu, 1, last_alu, r1, r2);
        end
      end
      issue("ir_idle", 0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, LW, 0, 0,
            0, 0, 5'd0, 32'h0, 0, r1, r2);
      drain();
      chk("instret_10", instret, 64'd10);
      @(negedge clk);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.instret_q;
      slot("ir_wrap", 1, 5'd1, 2'b00, 3'b000, 2'd0, 32'h0000_0ABC, 1, 32'h0000_0ABC, r1, r2);
      issue("ir_idle2", 0, 0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, LW, 0, 0,
            0, 0, 5'd0, 32'h0, 0, r1, r2);
      drain();
      chk("instret_wrap", instret, 64'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
